// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words from instruction
// memory, buffers {pc, instr} pairs in a small FIFO and hands them to decode.
module fetch_unit #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  input  logic        out_ready,
  output logic        halted
);

  localparam int unsigned W     = 16;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;

  state_t           state, state_next;
  logic [W-1:0]     fetch_pc, fetch_pc_next;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [CNT_W-1:0] count, count_next, count_popped;
  logic             push, pop;
  logic             out_valid_next;
  logic [W-1:0]     out_instr_next, out_pc_next, imem_addr_next;

  logic [W-1:0]     fifo_instr [DEPTH];
  logic [W-1:0]     fifo_pc    [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; a redirect overrides whatever the current state decided
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    pop           = out_valid & out_ready;
    count_popped  = count - CNT_W'(pop);
    case (state)
      IDLE: begin
        if (count < CNT_W'(DEPTH)) state_next = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + W'(2);
          if (imem_rdata == HALT_WORD)                          state_next = HALT;
          else if (count_popped + CNT_W'(1) < CNT_W'(DEPTH))    state_next = REQ;
          else                                                  state_next = IDLE;
        end
      end
      DISCARD: begin
        if (imem_ack) state_next = REQ;
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = IDLE;
    endcase
    if (redirect) begin
      push          = 1'b0;
      fetch_pc_next = redirect_pc & 16'hFFFE;
      // An outstanding request with no ack yet must be completed before refetching
      if ((state == REQ || state == DISCARD) && !imem_ack) state_next = DISCARD;
      else                                                 state_next = REQ;
    end
  end

  // FIFO bookkeeping and the registered head view
  always_comb begin
    rd_ptr_next    = pop  ? ptr_inc(rd_ptr) : rd_ptr;
    wr_ptr_next    = push ? ptr_inc(wr_ptr) : wr_ptr;
    count_next     = count_popped + CNT_W'(push);
    out_valid_next = 1'b0;
    out_instr_next = out_instr;
    out_pc_next    = out_pc;
    if (redirect) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else if (count_popped != '0) begin
      out_valid_next = 1'b1;
      out_instr_next = fifo_instr[rd_ptr_next];
      out_pc_next    = fifo_pc[rd_ptr_next];
    end else if (push) begin
      out_valid_next = 1'b1;
      out_instr_next = imem_rdata;
      out_pc_next    = fetch_pc;
    end
    imem_addr_next = (state_next == DISCARD) ? imem_addr : fetch_pc_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
    end else begin
      fetch_pc  <= fetch_pc_next;
      rd_ptr    <= rd_ptr_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      imem_req  <= (state_next == REQ) || (state_next == DISCARD);
      imem_addr <= imem_addr_next;
      out_valid <= out_valid_next;
      out_instr <= out_instr_next;
      out_pc    <= out_pc_next;
      halted    <= (state_next == HALT);
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: tests queue expected {pc, instr} pairs,
// a negedge monitor pops and compares every entry decode accepts.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready = 1'b0;
  logic        halted;

  fetch_unit #(.DEPTH(2), .HALT_WORD(16'hFFFF), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .halted(halted)
  );

  always #5 clock = ~clock;

  // Memory model: default word 0x7aaa from the low address bits, plus overrides
  logic [15:0] ov_addr [4];
  logic [15:0] ov_data [4];
  logic [3:0]  ov_en = 4'b0000;
  int unsigned lat = 0;
  int unsigned wait_cnt;
  int unsigned ack_cnt = 0;

  always_comb begin
    imem_rdata = {4'h7, imem_addr[11:0]};
    for (int i = 0; i < 4; i++)
      if (ov_en[i] && ov_addr[i] == imem_addr) imem_rdata = ov_data[i];
    imem_ack = imem_req && (wait_cnt >= lat);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                   wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end

  always_ff @(posedge clock) begin
    if (reset_n && imem_req && imem_ack) ack_cnt <= ack_cnt + 1;
  end

  logic [31:0] exp_q [$];
  int dir_pass = 0, dir_total = 0;
  int sb_pass = 0, sb_total = 0;

  always @(negedge clock) begin : monitor
    logic [31:0] e;
    if (reset_n && out_valid && out_ready) begin
      sb_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: actual pc=%h instr=%h required no entry", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} === e) sb_pass++;
        else $display("FAIL sb_entry: actual pc=%h instr=%h required pc=%h instr=%h",
                      out_pc, out_instr, e[31:16], e[15:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    dir_total++;
    if (act === exp) dir_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    redirect  = 1'b0;
    out_ready = 1'b0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [15:0] pc);
    redirect_pc = pc;
    redirect    = 1'b1;
    cyc(1);
    redirect    = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) cyc(1);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_ov(input int idx, input logic [15:0] a, input logic [15:0] d);
    ov_addr[idx] = a;
    ov_data[idx] = d;
    ov_en[idx]   = 1'b1;
  endtask

  int unsigned base;
  logic        seen;

  initial begin
    // Reset values
    cyc(2);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'h0000);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", 32'(out_instr), 32'h0000);
    check("rst_out_pc", 32'(out_pc), 32'h0000);
    check("rst_halted", 32'(halted), 32'd0);

    // Streaming with combinational memory up to the halt word
    ov_en = 4'b0000;
    set_ov(0, 16'h0000, 16'h710F);
    set_ov(1, 16'h0002, 16'h7207);
    set_ov(2, 16'h0004, 16'hFFFF);
    lat = 0;
    exp_q.push_back({16'h0000, 16'h710F});
    exp_q.push_back({16'h0002, 16'h7207});
    exp_q.push_back({16'h0004, 16'hFFFF});
    base = ack_cnt;
    do_reset();
    out_ready = 1'b1;
    drain("t1_drain");
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_acks", ack_cnt - base, 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | imem_req;
      cyc(1);
    end
    check("t1_req_after_halt", 32'(seen), 32'd0);

    // Backpressure fills the FIFO and stalls requests
    ov_en = 4'b0000;
    set_ov(0, 16'h0008, 16'hFFFF);
    do_reset();
    base = ack_cnt;
    cyc(8);
    check("t2_acks_stalled", ack_cnt - base, 32'd2);
    check("t2_req_stalled", 32'(imem_req), 32'd0);
    check("t2_valid_held", 32'(out_valid), 32'd1);
    check("t2_pc_held", 32'(out_pc), 32'h0000);
    check("t2_next_addr", 32'(imem_addr), 32'h0004);
    exp_q.push_back({16'h0000, 16'h7000});
    exp_q.push_back({16'h0002, 16'h7002});
    exp_q.push_back({16'h0004, 16'h7004});
    exp_q.push_back({16'h0006, 16'h7006});
    exp_q.push_back({16'h0008, 16'hFFFF});
    out_ready = 1'b1;
    drain("t2_drain");
    check("t2_halted", 32'(halted), 32'd1);

    // Slow memory; redirect while the request is outstanding
    ov_en = 4'b0000;
    set_ov(0, 16'h0042, 16'hFFFF);
    lat = 3;
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back({16'h0040, 16'h7040});
    exp_q.push_back({16'h0042, 16'hFFFF});
    for (int i = 0; i < 10 && !imem_req; i++) cyc(1);
    check("t3_req_seen", 32'(imem_req), 32'd1);
    cyc(1);
    pulse_redirect(16'h0041);
    check("t3_discard_req", 32'(imem_req), 32'd1);
    check("t3_discard_addr", 32'(imem_addr), 32'h0000);
    for (int i = 0; i < 10 && !imem_ack; i++) cyc(1);
    check("t3_old_ack_seen", 32'(imem_ack), 32'd1);
    cyc(1);
    check("t3_new_addr", 32'(imem_addr), 32'h0040);
    check("t3_new_req", 32'(imem_req), 32'd1);
    check("t3_no_stale_out", 32'(out_valid), 32'd0);
    drain("t3_drain");

    // Redirect in the same cycle decode pops pc=2
    ov_en = 4'b0000;
    set_ov(0, 16'h0022, 16'hFFFF);
    lat = 0;
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back({16'h0000, 16'h7000});
    exp_q.push_back({16'h0002, 16'h7002});
    exp_q.push_back({16'h0020, 16'h7020});
    exp_q.push_back({16'h0022, 16'hFFFF});
    for (int i = 0; i < 10 && !(out_valid && out_pc == 16'h0002); i++) cyc(1);
    check("t4_head_pc2", 32'(out_pc), 32'h0002);
    pulse_redirect(16'h0020);
    check("t4_flushed", 32'(out_valid), 32'd0);
    check("t4_target_addr", 32'(imem_addr), 32'h0020);
    drain("t4_drain");

    // PC wrap from 0xFFFE to 0x0000 (redirect bit 0 forced low)
    ov_en = 4'b0000;
    set_ov(0, 16'h0000, 16'hFFFF);
    set_ov(1, 16'h0014, 16'hFFFF);
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back({16'hFFFE, 16'h7FFE});
    exp_q.push_back({16'h0000, 16'hFFFF});
    pulse_redirect(16'hFFFF);
    check("t5_addr_fffe", 32'(imem_addr), 32'hFFFE);
    drain("t5_drain");
    check("t5_halted", 32'(halted), 32'd1);

    // Redirect out of HALT
    exp_q.push_back({16'h0010, 16'h7010});
    exp_q.push_back({16'h0012, 16'h7012});
    exp_q.push_back({16'h0014, 16'hFFFF});
    pulse_redirect(16'h0010);
    check("t6_unhalted", 32'(halted), 32'd0);
    check("t6_req", 32'(imem_req), 32'd1);
    check("t6_addr", 32'(imem_addr), 32'h0010);
    drain("t6_drain");
    check("t6_halted_again", 32'(halted), 32'd1);

    // Asynchronous reset in the middle of a stream
    out_ready = 1'b0;
    pulse_redirect(16'h0030);
    cyc(5);
    check("t6_pre_rst_valid", 32'(out_valid), 32'd1);
    check("t6_pre_rst_pc", 32'(out_pc), 32'h0030);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("arst_imem_req", 32'(imem_req), 32'd0);
    check("arst_imem_addr", 32'(imem_addr), 32'h0000);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_instr", 32'(out_instr), 32'h0000);
    check("arst_out_pc", 32'(out_pc), 32'h0000);
    check("arst_halted", 32'(halted), 32'd0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", dir_pass + sb_pass, dir_total + sb_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit single-cycle MIPS datapath. It sits directly upstream of decode (control unit and register file). It owns the fetch PC, issues word requests to instruction memory, and buffers returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake, handles branch redirects, and stops fetching at the halt word.

## Interface
- DEPTH, 2, instruction FIFO entries (>=1)
- HALT_WORD, 16'hFFFF, encoding that stops fetch
- RESET_PC, 16'h0000, fetch PC after reset (bit 0 must be 0)

- clock  in  1  rising-edge clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  request valid; held with imem_addr stable until imem_ack
- imem_addr  out  16  byte address of requested word (bit 0 always 0)
- imem_ack  in  1  request accepted and data valid this cycle; may be same cycle as imem_req rises
- imem_rdata  in  16  instruction word, valid when imem_ack=1
- redirect  in  1  one-cycle pulse: discard everything, refetch from redirect_pc
- redirect_pc  in  16  new fetch address; bit 0 ignored (forced 0)
- out_valid  out  1  FIFO head valid
- out_instr  out  16  FIFO head instruction
- out_pc  out  16  FIFO head byte address
- out_ready  in  1  decode accepts head when out_valid=1
- halted  out  1  HALT_WORD fetched; no further requests

## Operation
- State machine: IDLE, REQ, DISCARD, HALT.
- imem_req=1 only in REQ and DISCARD.
- IDLE: enter REQ when count < DEPTH.
- REQ: on imem_ack, push {fetch_pc, imem_rdata} and advance fetch_pc by 2.
  - fetch_pc wraps 16'hFFFE -> 16'h0000.
  - If imem_rdata == HALT_WORD, the word is still pushed and the next state is HALT.
  - Otherwise stay in REQ if post-update count < DEPTH, else go to IDLE.
- HALT: halted=1, no requests. Entries drain normally. Only reset or redirect leaves HALT.
- redirect (any state):
  - FIFO is flushed (count=0) and fetch_pc = {redirect_pc[15:1],1'b0}; halted cleared.
  - If the state is REQ and imem_ack is 0 that cycle, go to DISCARD.
  - Otherwise go to REQ; any imem_ack in the redirect cycle is dropped.
- DISCARD: hold imem_req/imem_addr of the abandoned request. On imem_ack, drop the data and go to REQ at the new fetch_pc. A second redirect in DISCARD only updates fetch_pc.
- imem_addr = old address during DISCARD, fetch_pc otherwise.
- FIFO: circular, DEPTH entries.
  - Push and pop in the same cycle are both honored; count unchanged.
  - Push is never attempted when full, because a request is issued only with a free slot.
  - Pop occurs when out_valid & out_ready.
- Redirect with a simultaneous pop: the pop completes (decode consumed it), then the flush applies.
- out_instr/out_pc reflect the head entry when out_valid=1. They hold their last value when empty (0 after reset).

## Timing
- Reset (async assert, released synchronously to clock): state IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0.
- First clock edge after reset_n rises: IDLE->REQ, so imem_req=1 in the following cycle.
- Ack sampled at edge N: entry visible on out_valid/out_instr/out_pc after edge N (registered); next imem_addr also updates at edge N.
- With imem_ack tied to imem_req (combinational memory) and out_ready=1: one instruction per cycle sustained, 1-cycle fetch-to-decode latency.
- halted rises at the edge that accepts HALT_WORD; imem_req=0 from that edge.
- Redirect at edge N: out_valid=0 after N; first new-target entry no earlier than the edge after the first post-redirect ack.
- Reset mid-request abandons the request immediately; memory must tolerate imem_req dropping.

## Test plan
- Reset then imem_ack=imem_req, out_ready=1, memory words 0x710F,0x7207,0xFFFF at 0,2,4 -> out_pc 0,2,4 on consecutive cycles. halted=1 after the third ack; imem_req stays 0 thereafter.
- out_ready=0 with DEPTH=2 -> exactly two acks, then imem_req=0 with out_valid=1 holding out_pc=0. Raising out_ready resumes fetch at addr 4 with no duplicate or lost PCs.
- Memory acks 3 cycles after req; redirect to 0x0041 while waiting -> imem_addr stays old until ack, that data is never presented, next request addr=0x0040, first out_pc=0x0040.
- Redirect same cycle as pop of head pc=2 -> pc=2 counted consumed once, FIFO empty next cycle, next out_pc=redirect target.
- fetch_pc at 0xFFFE -> out_pc 0xFFFE followed by 0x0000.
- After halt, redirect to 0x0010 -> halted=0, fetch resumes at 0x0010; reset_n pulse mid-stream -> all outputs to reset values asynchronously.
